// File: rtl/gate_pkg.sv
// gate_pkg: shared constants and operation encodings for the gate unit pipeline.
//   OP_W      - width of the operation select field
//   STAT_W    - width of the optional output-handshake counter
//   gate_op_e - 3-bit operation encoding (all 8 codes legal)
package gate_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_NOT  = 3'd0,
        OP_BUF  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_XNOR = 3'd7
    } gate_op_e;

endpackage

// File: rtl/gate_pipe_stage.sv
// gate_pipe_stage: one valid/data/op register stage of the gate pipeline.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   ready               - this stage may load this cycle (resolved by the parent ready chain)
//   up_valid/data/op    - upstream stage contents (or the input operand set)
//   valid/data/op       - registered stage contents
module gate_pipe_stage
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ready,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic [OP_W-1:0]  up_op,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [OP_W-1:0]  op
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            op    <= '0;
        end else if (ready) begin
            valid <= up_valid;
            // Payload only moves with a real item; a bubble leaves stale data behind.
            if (up_valid) begin
                data <= up_data;
                op   <= up_op;
            end
        end
    end

endmodule

// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe: bitwise gate (NOT/BUF/AND/OR/XOR/NAND/NOR/XNOR) on WIDTH-bit operands,
// carried through STAGES registered stages with valid/ready flow control.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   in_valid/in_ready           - input handshake
//   in_op, in_a, in_b           - operation select and operands (in_b unused for NOT/BUF)
//   out_valid/out_ready         - output handshake
//   out_data, out_op            - result and the op that produced it
//   stat_count                  - saturating output-handshake count (GATE_UNIT_STATS_EN only)
// Optional feature macro: GATE_UNIT_STATS_EN.
module gate_unit_pipe
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [OP_W-1:0]   out_op
`ifdef GATE_UNIT_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_count
`endif
);

    logic [WIDTH-1:0] result;

    // Index 0 is the input side; index i+1 is the output of stage i.
    logic             stage_valid [STAGES+1];
    logic [WIDTH-1:0] stage_data  [STAGES+1];
    logic [OP_W-1:0]  stage_op    [STAGES+1];
    logic             stage_ready [STAGES+1];

    always_comb begin
        result = '0;
        case (gate_op_e'(in_op))
            OP_NOT:  result = ~in_a;
            OP_BUF:  result = in_a;
            OP_AND:  result = in_a & in_b;
            OP_OR:   result = in_a | in_b;
            OP_XOR:  result = in_a ^ in_b;
            OP_NAND: result = ~(in_a & in_b);
            OP_NOR:  result = ~(in_a | in_b);
            OP_XNOR: result = ~(in_a ^ in_b);
            default: result = '0;
        endcase
    end

    assign stage_valid[0] = in_valid;
    assign stage_data[0]  = result;
    assign stage_op[0]    = in_op;

    // ready_i = !valid_i | ready_(i+1), resolved in one block from the registered valids
    // so the chain is a single combinational path with no apparent loop.
    always_comb begin
        for (int i = 0; i <= STAGES; i++) begin
            stage_ready[i] = 1'b0;
        end
        stage_ready[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            stage_ready[i] = !stage_valid[i+1] || stage_ready[i+1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        gate_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .ready    (stage_ready[g]),
            .up_valid (stage_valid[g]),
            .up_data  (stage_data[g]),
            .up_op    (stage_op[g]),
            .valid    (stage_valid[g+1]),
            .data     (stage_data[g+1]),
            .op       (stage_op[g+1])
        );
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = stage_valid[STAGES];
    assign out_data  = stage_data[STAGES];
    assign out_op    = stage_op[STAGES];

`ifdef GATE_UNIT_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_count <= '0;
        end else if (out_valid && out_ready && (stat_count != {STAT_W{1'b1}})) begin
            stat_count <= stat_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Bench for gate_unit_pipe: an 8-bit/2-stage instance for the op sweep and flow-control
// corners, and a 1-bit/1-stage instance for inverter equivalence.
// stat_count is checked when GATE_UNIT_STATS_EN is defined.
module tb_gate_unit_pipe;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] in_op, out_op;
    logic [7:0] in_a, in_b, out_data;

    logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready;
    logic [2:0] w1_in_op, w1_out_op;
    logic [0:0] w1_in_a, w1_in_b, w1_out_data;

`ifdef GATE_UNIT_STATS_EN
    logic [15:0] stat_count, w1_stat_count;
`endif

    int total;
    int passed;

    gate_unit_pipe #(
        .WIDTH  (8),
        .STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_op     (out_op)
`ifdef GATE_UNIT_STATS_EN
        ,
        .stat_count (stat_count)
`endif
    );

    gate_unit_pipe #(
        .WIDTH  (1),
        .STAGES (1)
    ) dut_w1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (w1_in_valid),
        .in_ready   (w1_in_ready),
        .in_op      (w1_in_op),
        .in_a       (w1_in_a),
        .in_b       (w1_in_b),
        .out_valid  (w1_out_valid),
        .out_ready  (w1_out_ready),
        .out_data   (w1_out_data),
        .out_op     (w1_out_op)
`ifdef GATE_UNIT_STATS_EN
        ,
        .stat_count (w1_stat_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } sweep_vec_t;

    typedef struct {
        logic a;
        logic exp;
    } inv_vec_t;

    sweep_vec_t sweep[8];
    inv_vec_t   inv[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;

        sweep[0] = '{3'd0, 8'hA5, 8'h0F, 8'h5A};
        sweep[1] = '{3'd1, 8'hA5, 8'h0F, 8'hA5};
        sweep[2] = '{3'd2, 8'hA5, 8'h0F, 8'h05};
        sweep[3] = '{3'd3, 8'hA5, 8'h0F, 8'hAF};
        sweep[4] = '{3'd4, 8'hA5, 8'h0F, 8'hAA};
        sweep[5] = '{3'd5, 8'hA5, 8'h0F, 8'hFA};
        sweep[6] = '{3'd6, 8'hA5, 8'h0F, 8'h50};
        sweep[7] = '{3'd7, 8'hA5, 8'h0F, 8'h55};

        inv[0] = '{1'b0, 1'b1};
        inv[1] = '{1'b1, 1'b0};
        inv[2] = '{1'b0, 1'b1};
        inv[3] = '{1'b1, 1'b0};
        inv[4] = '{1'b0, 1'b1};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_op        = 3'd0;
        in_a         = 8'h00;
        in_b         = 8'h00;
        out_ready    = 1'b0;
        w1_in_valid  = 1'b0;
        w1_in_op     = 3'd0;
        w1_in_a      = 1'b0;
        w1_in_b      = 1'b0;
        w1_out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_op", out_op, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_w1_out_valid", w1_out_valid, 0);
        check("rst_w1_out_data", w1_out_data, 0);
        rst_n        = 1'b1;
        out_ready    = 1'b1;
        w1_out_ready = 1'b1;

        // Op sweep: item c driven in window c appears at window c+2
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                in_op    = sweep[c].op;
                in_a     = sweep[c].a;
                in_b     = sweep[c].b;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 2) begin
                check($sformatf("sweep_valid_%0d", c - 2), out_valid, 1);
                check($sformatf("sweep_data_%0d", c - 2), out_data, sweep[c-2].exp);
                check($sformatf("sweep_op_%0d", c - 2), out_op, sweep[c-2].op);
            end else begin
                check($sformatf("sweep_latency_%0d", c), out_valid, 0);
            end
            tick();
        end
        check("sweep_drain", out_valid, 0);

        // 1-bit, 1-stage inverter: each result one cycle after acceptance
        w1_in_op = 3'd0;
        for (int c = 0; c < 6; c++) begin
            if (c < 5) begin
                w1_in_valid = 1'b1;
                w1_in_a     = inv[c].a;
            end else begin
                w1_in_valid = 1'b0;
            end
            #1;
            if (c >= 1) begin
                check($sformatf("inv_valid_%0d", c - 1), w1_out_valid, 1);
                check($sformatf("inv_data_%0d", c - 1), w1_out_data, inv[c-1].exp);
            end else begin
                check("inv_latency", w1_out_valid, 0);
            end
            tick();
        end
        check("inv_drain", w1_out_valid, 0);

        // Backpressure fill, then release with simultaneous accept/emit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd1;
        in_b      = 8'h00;
        in_a      = 8'h01;
        #1;
        check("bp_ready_1", in_ready, 1);
        tick();
        in_a = 8'h02;
        #1;
        check("bp_ready_2", in_ready, 1);
        tick();
        in_a = 8'h03;
        #1;
        check("bp_ready_full", in_ready, 0);
        check("bp_valid_full", out_valid, 1);
        check("bp_data_full", out_data, 8'h01);
        tick();
        check("bp_data_hold", out_data, 8'h01);
        check("bp_op_hold", out_op, 3'd1);
        check("bp_ready_hold", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("bp_ready_release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        check("bp_out2_valid", out_valid, 1);
        check("bp_out2_data", out_data, 8'h02);
        tick();
        check("bp_out3_valid", out_valid, 1);
        check("bp_out3_data", out_data, 8'h03);
        tick();
        check("bp_drain", out_valid, 0);

        // Bubble compression: valid 1/0/1/0 into a stalled pipe
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c % 2 == 0);
            in_a     = (c == 0) ? 8'h11 : 8'h22;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("bub_ready_full", in_ready, 0);
        check("bub_out1_valid", out_valid, 1);
        check("bub_out1_data", out_data, 8'h11);
        out_ready = 1'b1;
        tick();
        check("bub_out2_valid", out_valid, 1);
        check("bub_out2_data", out_data, 8'h22);
        tick();
        check("bub_drain", out_valid, 0);

        // Mid-operation reset discards two in-flight items
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'h33;
        tick();
        in_a = 8'h44;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data", out_data, 0);
        check("mrst_out_op", out_op, 0);
        check("mrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("mrst_no_stale_%0d", c), out_valid, 0);
        end

`ifdef GATE_UNIT_STATS_EN
        check("stat_after_reset", stat_count, 16'd0);
        in_valid = 1'b1;
        in_op    = 3'd1;
        for (int c = 0; c < 5; c++) begin
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
        end
        check("stat_five", stat_count, 16'd5);
        in_valid = 1'b1;
        for (int c = 0; c < 65535; c++) begin
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
        end
        check("stat_saturate", stat_count, 16'hFFFF);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("stat_reset", stat_count, 16'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
